// File: rtl/ddr_read_arbiter_if.sv
// Avalon-MM read port bundle: address/read command, waitrequest stall,
// and the readdata/readdatavalid return path.
// Ports (master view): out addr, read; in waitrequest, readdata, readdatavalid.
interface ddr_read_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output addr, read,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  addr, read,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/ddr_read_arbiter.sv
// Shares one DDR3 Avalon-MM read port between two read requesters.
// Round-robin grant, lock across DDR stalls, and an in-order ID FIFO
// that routes each returned word back to the requester that issued it.
// Ports: clk, reset (sync, active-high); m0/m1 slave read ports;
//   ddr master read port; pending = reads in flight;
//   err_orphan = sticky, a response arrived with nothing outstanding.
// Macro DDR_ARB_PRIORITY_M0_EN: requester 0 wins every contended cycle.
module ddr_read_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 16,
    parameter int MAX_OUTSTANDING = 8,
    localparam int PTR_W = $clog2(MAX_OUTSTANDING),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    ddr_read_arbiter_if.slave  m0,
    ddr_read_arbiter_if.slave  m1,
    ddr_read_arbiter_if.master ddr,
    output logic [CNT_W-1:0]   pending,
    output logic               err_orphan
);

    typedef enum logic [1:0] {
        ST_OPEN,
        ST_LOCK0,
        ST_LOCK1
    } lock_state_t;

    lock_state_t state_q, state_d;

    logic                       last_grant;
    logic                       gnt_vld;
    logic                       gnt_id;
    logic                       full;
    logic                       empty;
    logic                       accept;
    logic                       pop;
    logic                       head;
    logic                       cmd_read;
    logic [ADDR_W-1:0]          addr_sel;

    logic [MAX_OUTSTANDING-1:0] id_mem;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;

    logic                       v0_q;
    logic                       v1_q;
    logic [DATA_W-1:0]          rd0_q;
    logic [DATA_W-1:0]          rd1_q;

    assign full  = (pending == CNT_W'(MAX_OUTSTANDING));
    assign empty = (pending == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant selection and lock tracking. A stalled command keeps its
    // requester locked so the address seen by the DDR port cannot change
    // until the command is taken.
    always_comb begin
        state_d  = ST_OPEN;
        gnt_vld  = 1'b0;
        gnt_id   = 1'b0;
        cmd_read = 1'b0;
        if (!full) begin
            unique case (state_q)
                ST_LOCK0: begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b0;
                end
                ST_LOCK1: begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b1;
                end
                default: begin
                    if (m0.read && m1.read) begin
                        gnt_vld = 1'b1;
`ifdef DDR_ARB_PRIORITY_M0_EN
                        gnt_id  = 1'b0;
`else
                        gnt_id  = ~last_grant;
`endif
                    end else if (m0.read) begin
                        gnt_vld = 1'b1;
                        gnt_id  = 1'b0;
                    end else if (m1.read) begin
                        gnt_vld = 1'b1;
                        gnt_id  = 1'b1;
                    end
                end
            endcase
        end
        if (gnt_vld) begin
            cmd_read = gnt_id ? m1.read : m0.read;
        end
        if (cmd_read && ddr.waitrequest) begin
            state_d = gnt_id ? ST_LOCK1 : ST_LOCK0;
        end
    end

    // gnt_id is 0 whenever nothing is granted, so idle cycles present m0_addr.
    assign addr_sel = gnt_id ? m1.addr : m0.addr;

    assign ddr.addr = addr_sel;
    assign ddr.read = cmd_read;

    assign m0.waitrequest = !(gnt_vld && !gnt_id) || ddr.waitrequest;
    assign m1.waitrequest = !(gnt_vld &&  gnt_id) || ddr.waitrequest;

    assign accept = cmd_read && !ddr.waitrequest;
    assign pop    = ddr.readdatavalid && !empty;
    assign head   = id_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (accept) begin
            id_mem[wr_ptr] <= gnt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pending    <= '0;
            last_grant <= 1'b1;
            err_orphan <= 1'b0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            rd0_q      <= '0;
            rd1_q      <= '0;
        end else begin
            if (accept) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= gnt_id;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                pending <= pending + 1'b1;
            end else if (pop && !accept) begin
                pending <= pending - 1'b1;
            end
            if (ddr.readdatavalid && empty) begin
                err_orphan <= 1'b1;
            end
            v0_q <= pop && !head;
            v1_q <= pop && head;
            if (pop && !head) begin
                rd0_q <= ddr.readdata;
            end
            if (pop && head) begin
                rd1_q <= ddr.readdata;
            end
        end
    end

    assign m0.readdatavalid = v0_q;
    assign m1.readdatavalid = v1_q;
    assign m0.readdata      = rd0_q;
    assign m1.readdata      = rd1_q;

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Self-checking bench for ddr_read_arbiter: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_ddr_read_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 16;
    localparam int MAXO = 8;
    localparam int PW   = $clog2(MAXO) + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ddr_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    ddr_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
    ddr_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ddr_if ();

    logic [PW-1:0] pending;
    logic          err_orphan;

    ddr_read_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset),
        .m0(m0_if), .m1(m1_if), .ddr(ddr_if),
        .pending(pending), .err_orphan(err_orphan)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner queue, lock owner, last winner.
    int            m_own[$];
    int            m_last;
    int            m_lock;
    int            m_g;
    bit            m_orph;
    bit            m_v0, m_v1;
    logic [DW-1:0] m_rd0, m_rd1;

    bit            i_w, i_rv;
    logic [DW-1:0] i_rd;
    bit            e_read, e_w0, e_w1;
    logic [AW-1:0] e_addr;
    logic [PW-1:0] e_pend;

    function automatic int pick(bit r0, bit r1);
        if (m_own.size() == MAXO) return -1;
        if (m_lock >= 0) return m_lock;
        if (r0 && r1) begin
`ifdef DDR_ARB_PRIORITY_M0_EN
            return 0;
`else
            return (m_last == 0) ? 1 : 0;
`endif
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic put(input bit r0, input logic [AW-1:0] a0,
                       input bit r1, input logic [AW-1:0] a1,
                       input bit w, input bit rv, input logic [DW-1:0] rd);
        m0_if.read = r0;
        m0_if.addr = a0;
        m1_if.read = r1;
        m1_if.addr = a1;
        ddr_if.waitrequest   = w;
        ddr_if.readdatavalid = rv;
        ddr_if.readdata      = rd;
        i_w  = w;
        i_rv = rv;
        i_rd = rd;
        m_g    = pick(r0, r1);
        e_read = (m_g >= 0);
        e_addr = (m_g == 1) ? a1 : a0;
        e_w0   = (m_g != 0) || w;
        e_w1   = (m_g != 1) || w;
        #1;
    endtask

    task automatic tick();
        int id;
        @(posedge clk);
        if (reset) begin
            m_own.delete();
            m_lock = -1;
            m_last = 1;
            m_orph = 0;
            m_v0   = 0;
            m_v1   = 0;
            m_rd0  = '0;
            m_rd1  = '0;
        end else begin
            m_v0 = 0;
            m_v1 = 0;
            if (i_rv) begin
                if (m_own.size() == 0) begin
                    m_orph = 1;
                end else begin
                    id = m_own.pop_front();
                    if (id == 0) begin
                        m_v0 = 1;
                        m_rd0 = i_rd;
                    end else begin
                        m_v1 = 1;
                        m_rd1 = i_rd;
                    end
                end
            end
            if (m_g >= 0 && !i_w) begin
                m_own.push_back(m_g);
                m_last = m_g;
            end
            m_lock = (m_g >= 0 && i_w) ? m_g : -1;
        end
        e_pend = PW'(m_own.size());
        #1;
    endtask

    task automatic idle();
        put(0, '0, 0, '0, 0, 0, '0);
        tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        put(0, '0, 0, '0, 0, 0, '0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        put(0, 32'h55, 0, 32'h66, 0, 0, '0);
        checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending got %0d want 0", pending); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan got %b want 0", err_orphan); end
        checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_v0 got %b want 0", m0_if.readdatavalid); end
        checks++; if (m1_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_v1 got %b want 0", m1_if.readdatavalid); end
        checks++; if (m0_if.readdata !== '0) begin errors++; $display("FAIL reset_rd0 got %h want 0", m0_if.readdata); end
        checks++; if (m1_if.readdata !== '0) begin errors++; $display("FAIL reset_rd1 got %h want 0", m1_if.readdata); end
        checks++; if (ddr_if.read !== 1'b0) begin errors++; $display("FAIL reset_ddr_read got %b want 0", ddr_if.read); end
        checks++; if (ddr_if.addr !== 32'h55) begin errors++; $display("FAIL idle_addr got %h want 55", ddr_if.addr); end
        tick();
    endtask

    task automatic test_single();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            a = AW'(32'h10 + k);
            put(1, a, 0, '0, 0, 0, '0);
            checks++; if (ddr_if.addr !== a || ddr_if.read !== 1'b1) begin errors++; $display("FAIL single_cmd got %h/%b want %h/1", ddr_if.addr, ddr_if.read, a); end
            checks++; if (m0_if.waitrequest !== 1'b0) begin errors++; $display("FAIL single_wait got %b want 0", m0_if.waitrequest); end
            tick();
        end
        checks++; if (pending !== PW'(3)) begin errors++; $display("FAIL single_peak got %0d want 3", pending); end
        idle();
        idle();
        for (int k = 0; k < 3; k++) begin
            d = DW'(16'h0A01 + k);
            put(0, '0, 0, '0, 0, 1, d);
            tick();
            checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== d) begin errors++; $display("FAIL single_resp got %b/%h want 1/%h", m0_if.readdatavalid, m0_if.readdata, d); end
            checks++; if (m1_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL single_m1v got %b want 0", m1_if.readdatavalid); end
        end
        idle();
        checks++; if (m0_if.readdatavalid !== 1'b0 || m0_if.readdata !== 16'h0A03) begin errors++; $display("FAIL single_hold got %b/%h want 0/0a03", m0_if.readdatavalid, m0_if.readdata); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL single_drain got %0d want 0", pending); end
    endtask

    task automatic test_contention();
        int            eid[6];
        logic [AW-1:0] ea;
        logic [DW-1:0] d;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
`ifdef DDR_ARB_PRIORITY_M0_EN
            eid[k] = 0;
`else
            eid[k] = k % 2;
`endif
            ea = (eid[k] == 0) ? AW'(32'h100 + k) : AW'(32'h200 + k);
            put(1, AW'(32'h100 + k), 1, AW'(32'h200 + k), 0, 0, '0);
            checks++; if (ddr_if.addr !== ea) begin errors++; $display("FAIL cont_grant%0d got %h want %h", k, ddr_if.addr, ea); end
            checks++; if (m0_if.waitrequest !== (eid[k] != 0) || m1_if.waitrequest !== (eid[k] != 1)) begin errors++; $display("FAIL cont_wait%0d got %b%b", k, m0_if.waitrequest, m1_if.waitrequest); end
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            d = DW'(16'h1000 + k);
            put(0, '0, 0, '0, 0, 1, d);
            tick();
            if (eid[k] == 0) begin
                checks++; if (m0_if.readdatavalid !== 1'b1 || m1_if.readdatavalid !== 1'b0 || m0_if.readdata !== d) begin errors++; $display("FAIL cont_route%0d got %b%b/%h want 10/%h", k, m0_if.readdatavalid, m1_if.readdatavalid, m0_if.readdata, d); end
            end else begin
                checks++; if (m1_if.readdatavalid !== 1'b1 || m0_if.readdatavalid !== 1'b0 || m1_if.readdata !== d) begin errors++; $display("FAIL cont_route%0d got %b%b/%h want 01/%h", k, m0_if.readdatavalid, m1_if.readdatavalid, m1_if.readdata, d); end
            end
        end
    endtask

    task automatic test_stall_lock();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            put(k != 0, 32'h400, 1, 32'h300, 1, 0, '0);
            checks++; if (ddr_if.addr !== 32'h300 || ddr_if.read !== 1'b1) begin errors++; $display("FAIL lock_addr%0d got %h want 300", k, ddr_if.addr); end
            checks++; if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL lock_wait%0d got %b%b want 11", k, m0_if.waitrequest, m1_if.waitrequest); end
            tick();
        end
        put(1, 32'h400, 1, 32'h300, 0, 0, '0);
        checks++; if (ddr_if.addr !== 32'h300 || m1_if.waitrequest !== 1'b0 || m0_if.waitrequest !== 1'b1) begin errors++; $display("FAIL lock_accept got %h/%b%b want 300/10", ddr_if.addr, m0_if.waitrequest, m1_if.waitrequest); end
        tick();
        put(1, 32'h400, 1, 32'h301, 0, 0, '0);
        checks++; if (ddr_if.addr !== 32'h400 || m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL lock_next got %h/%b%b want 400/01", ddr_if.addr, m0_if.waitrequest, m1_if.waitrequest); end
        tick();
        put(0, '0, 0, '0, 0, 1, 16'h5101);
        tick();
        checks++; if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== 16'h5101) begin errors++; $display("FAIL lock_resp1 got %b/%h want 1/5101", m1_if.readdatavalid, m1_if.readdata); end
        put(0, '0, 0, '0, 0, 1, 16'h5100);
        tick();
        checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 16'h5100) begin errors++; $display("FAIL lock_resp0 got %b/%h want 1/5100", m0_if.readdatavalid, m0_if.readdata); end
    endtask

    task automatic test_fifo_full();
        logic [DW-1:0] d;
        apply_reset();
        for (int k = 0; k < MAXO; k++) begin
            put(1, AW'(32'h500 + k), 0, '0, 0, 0, '0);
            tick();
        end
        checks++; if (pending !== PW'(MAXO)) begin errors++; $display("FAIL full_pending got %0d want %0d", pending, MAXO); end
        put(1, 32'h5FF, 1, 32'h6FF, 0, 0, '0);
        checks++; if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1 || ddr_if.read !== 1'b0) begin errors++; $display("FAIL full_block got %b%b/%b want 11/0", m0_if.waitrequest, m1_if.waitrequest, ddr_if.read); end
        tick();
        put(1, 32'h5FF, 0, '0, 0, 1, 16'hBEEF);
        checks++; if (ddr_if.read !== 1'b0) begin errors++; $display("FAIL full_popblock got %b want 0", ddr_if.read); end
        tick();
        checks++; if (pending !== PW'(MAXO - 1) || m0_if.readdata !== 16'hBEEF) begin errors++; $display("FAIL full_pop got %0d/%h want 7/beef", pending, m0_if.readdata); end
        put(1, 32'h5FF, 0, '0, 0, 0, '0);
        checks++; if (ddr_if.read !== 1'b1 || m0_if.waitrequest !== 1'b0 || ddr_if.addr !== 32'h5FF) begin errors++; $display("FAIL full_resume got %b/%b/%h", ddr_if.read, m0_if.waitrequest, ddr_if.addr); end
        tick();
        checks++; if (pending !== PW'(MAXO)) begin errors++; $display("FAIL full_refill got %0d want %0d", pending, MAXO); end
        for (int k = 0; k < MAXO; k++) begin
            d = DW'(16'hC000 + k);
            put(0, '0, 0, '0, 0, 1, d);
            tick();
            checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== d) begin errors++; $display("FAIL full_drain%0d got %b/%h want 1/%h", k, m0_if.readdatavalid, m0_if.readdata, d); end
        end
        checks++; if (pending !== '0) begin errors++; $display("FAIL full_empty got %0d want 0", pending); end
    endtask

    task automatic test_orphan();
        apply_reset();
        put(1, 32'h700, 0, '0, 0, 0, '0);
        tick();
        put(0, '0, 1, 32'h701, 0, 0, '0);
        tick();
        checks++; if (pending !== PW'(2)) begin errors++; $display("FAIL orphan_pre got %0d want 2", pending); end
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            put(0, '0, 0, '0, 0, 1, 16'hDEAD);
            tick();
            checks++; if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL orphan_valid%0d got %b%b want 00", k, m0_if.readdatavalid, m1_if.readdatavalid); end
            checks++; if (err_orphan !== 1'b1 || pending !== '0) begin errors++; $display("FAIL orphan_flag%0d got %b/%0d want 1/0", k, err_orphan, pending); end
        end
    endtask

`ifdef DDR_ARB_PRIORITY_M0_EN
    task automatic test_priority();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            put(1, AW'(32'h800 + k), 1, 32'h900, 0, 0, '0);
            checks++; if (ddr_if.addr !== AW'(32'h800 + k) || m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL prio_m0_%0d got %h/%b", k, ddr_if.addr, m1_if.waitrequest); end
            tick();
        end
        put(0, '0, 1, 32'h900, 0, 0, '0);
        checks++; if (ddr_if.addr !== 32'h900 || m1_if.waitrequest !== 1'b0) begin errors++; $display("FAIL prio_m1 got %h/%b want 900/0", ddr_if.addr, m1_if.waitrequest); end
        tick();
        for (int k = 0; k < 5; k++) begin
            put(0, '0, 0, '0, 0, 1, DW'(k));
            tick();
        end
    endtask
`endif

    task automatic test_random();
        bit            r0, r1, h0, h1, w, rv;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] rd;
        apply_reset();
        r0 = 0; r1 = 0; h0 = 0; h1 = 0;
        a0 = '0; a1 = '0;
        for (int c = 0; c < 500; c++) begin
            if (!h0) begin r0 = ($urandom_range(0, 2) != 0); a0 = $urandom; end
            if (!h1) begin r1 = ($urandom_range(0, 2) != 0); a1 = $urandom; end
            w  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 2) == 0) && (m_own.size() > 0 || $urandom_range(0, 29) == 0);
            rd = DW'($urandom);
            put(r0, a0, r1, a1, w, rv, rd);
            checks++; if (ddr_if.read !== e_read || ddr_if.addr !== e_addr) begin errors++; $display("FAIL rnd_cmd c%0d got %b/%h want %b/%h", c, ddr_if.read, ddr_if.addr, e_read, e_addr); end
            checks++; if (m0_if.waitrequest !== e_w0 || m1_if.waitrequest !== e_w1) begin errors++; $display("FAIL rnd_wait c%0d got %b%b want %b%b", c, m0_if.waitrequest, m1_if.waitrequest, e_w0, e_w1); end
            h0 = r0 && e_w0;
            h1 = r1 && e_w1;
            tick();
            checks++; if (m0_if.readdatavalid !== m_v0 || m1_if.readdatavalid !== m_v1) begin errors++; $display("FAIL rnd_valid c%0d got %b%b want %b%b", c, m0_if.readdatavalid, m1_if.readdatavalid, m_v0, m_v1); end
            checks++; if (m0_if.readdata !== m_rd0 || m1_if.readdata !== m_rd1) begin errors++; $display("FAIL rnd_data c%0d got %h/%h want %h/%h", c, m0_if.readdata, m1_if.readdata, m_rd0, m_rd1); end
            checks++; if (pending !== e_pend || err_orphan !== m_orph) begin errors++; $display("FAIL rnd_state c%0d got %0d/%b want %0d/%b", c, pending, err_orphan, e_pend, m_orph); end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_stall_lock();
        test_fifo_full();
        test_orphan();
`ifdef DDR_ARB_PRIORITY_M0_EN
        test_priority();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
